// File: rtl/tick_scheduler.sv
// Multi-channel countdown timer scheduler sharing one base-tick prescaler.
// Optional macro TICK_SCHED_PAUSE_EN adds a 'pause' input that freezes the prescaler and all channels.
module tick_scheduler #(
    parameter int INPUT_FREQUENCY = 100_000_000,
    parameter int TICK_Hz         = 1000,
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 16,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_cmd,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              irq_ack,
`ifdef TICK_SCHED_PAUSE_EN
    input  logic              pause,
`endif
    output logic              base_tick,
    output logic [NUM_CH-1:0] ch_active,
    output logic [NUM_CH-1:0] ch_expire,
    output logic              irq,
    output logic [CH_W-1:0]   irq_ch
);

    localparam int TICK_COUNT = INPUT_FREQUENCY / TICK_Hz;
    localparam int PS_W       = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_COUNT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ONCE = 2'd1;
    localparam logic [1:0] ST_PER  = 2'd2;

    localparam logic [1:0] CMD_STOP   = 2'b00;
    localparam logic [1:0] CMD_ONCE   = 2'b01;
    localparam logic [1:0] CMD_PER    = 2'b10;
    localparam logic [1:0] CMD_RELOAD = 2'b11;

    logic [PS_W-1:0]   psCnt_q, psCnt_d;
    logic              tick_q, tick_d;
    logic              run;
    logic              tickEn;

    logic [1:0]        state_q  [NUM_CH];
    logic [1:0]        state_d  [NUM_CH];
    logic [CNT_W-1:0]  remain_q [NUM_CH];
    logic [CNT_W-1:0]  remain_d [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [NUM_CH-1:0] expire_q, expire_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] cfgHit;
    logic [CH_W-1:0]   irqSel;

`ifdef TICK_SCHED_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    // A tick generated just as pause rises is held in tick_q and released with the prescaler.
    always_comb begin
        psCnt_d = psCnt_q;
        tick_d  = tick_q;
        if (run) begin
            tick_d  = (psCnt_q == PS_LAST);
            psCnt_d = (psCnt_q == PS_LAST) ? '0 : psCnt_q + PS_W'(1);
        end
    end

    assign tickEn    = tick_q & run;
    assign base_tick = tickEn;

    always_comb begin
        cfgHit = '0;
        if (cfg_we && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH))) begin
            cfgHit[cfg_ch] = 1'b1;
        end
    end

    // A config write to a channel takes precedence over its countdown in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]  = state_q[i];
            remain_d[i] = remain_q[i];
            period_d[i] = period_q[i];
            expire_d[i] = 1'b0;
            if (cfgHit[i]) begin
                case (cfg_cmd)
                    CMD_STOP: begin
                        state_d[i]  = ST_IDLE;
                        remain_d[i] = '0;
                    end
                    CMD_ONCE, CMD_PER: begin
                        if (cfg_period != '0) begin
                            remain_d[i] = cfg_period;
                            period_d[i] = cfg_period;
                            state_d[i]  = (cfg_cmd == CMD_ONCE) ? ST_ONCE : ST_PER;
                        end
                    end
                    CMD_RELOAD: begin
                        if (state_q[i] != ST_IDLE) begin
                            remain_d[i] = period_q[i];
                        end
                    end
                    default: begin
                        state_d[i] = state_q[i];
                    end
                endcase
            end else if (tickEn && (state_q[i] != ST_IDLE)) begin
                if (remain_q[i] == CNT_W'(1)) begin
                    expire_d[i] = 1'b1;
                    if (state_q[i] == ST_ONCE) begin
                        state_d[i]  = ST_IDLE;
                        remain_d[i] = '0;
                    end else begin
                        remain_d[i] = period_q[i];
                    end
                end else begin
                    remain_d[i] = remain_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        irqSel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                irqSel = CH_W'(i);
            end
        end
    end

    assign irq    = |pending_q;
    assign irq_ch = irqSel;

    // An expiry on the same edge as its acknowledge keeps the pending bit set.
    always_comb begin
        pending_d = pending_q;
        if (irq_ack && irq) begin
            pending_d[irqSel] = 1'b0;
        end
        pending_d = pending_d | expire_d;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_active[i] = (state_q[i] != ST_IDLE);
        end
    end

    assign ch_expire = expire_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psCnt_q   <= '0;
            tick_q    <= 1'b0;
            expire_q  <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                remain_q[i] <= '0;
                period_q[i] <= '0;
            end
        end else begin
            psCnt_q   <= psCnt_d;
            tick_q    <= tick_d;
            expire_q  <= expire_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                remain_q[i] <= remain_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus random traffic against a behavioural model.
// Runs at TICK_COUNT=10, NUM_CH=4; the pause check only exists when TICK_SCHED_PAUSE_EN is defined.
module tb_tick_scheduler;

    localparam int NCH = 4;
    localparam int TC  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_cmd = '0;
    logic [15:0] cfg_period = '0;
    logic        irq_ack = 1'b0;
`ifdef TICK_SCHED_PAUSE_EN
    logic        pauseIn = 1'b0;
`endif
    logic        base_tick;
    logic [3:0]  ch_active;
    logic [3:0]  ch_expire;
    logic        irq;
    logic [1:0]  irq_ch;

    int compareCount = 0;
    int mismatchCount = 0;

    // Model: mode 0 idle, 1 one-shot, 2 periodic; counts are plain integers.
    int       mMode [NCH];
    int       mRem  [NCH];
    int       mPer  [NCH];
    bit [3:0] mPend;
    bit [3:0] mExpire;
    bit       mBase;
    int       mEdges;

    always #5 clk = ~clk;

    tick_scheduler #(
        .INPUT_FREQUENCY(10),
        .TICK_Hz        (1),
        .NUM_CH         (NCH),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_cmd   (cfg_cmd),
        .cfg_period(cfg_period),
        .irq_ack   (irq_ack),
`ifdef TICK_SCHED_PAUSE_EN
        .pause     (pauseIn),
`endif
        .base_tick (base_tick),
        .ch_active (ch_active),
        .ch_expire (ch_expire),
        .irq       (irq),
        .irq_ch    (irq_ch)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        compareCount++;
        if (observed !== 32'(expected)) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int lowestPending();
        for (int i = 0; i < NCH; i++) begin
            if (mPend[i]) return i;
        end
        return 0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            mMode[i] = 0;
            mRem[i]  = 0;
            mPer[i]  = 0;
        end
        mPend   = '0;
        mExpire = '0;
        mBase   = 1'b0;
        mEdges  = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input bit we, input int ch, input int cmd, input int per, input bit ack);
        bit       irqNow;
        int       sel;
        bit [3:0] activeMask;
        cfg_we     = we;
        cfg_ch     = ch[1:0];
        cfg_cmd    = cmd[1:0];
        cfg_period = per[15:0];
        irq_ack    = ack;

        irqNow  = (mPend != 0);
        sel     = lowestPending();
        mExpire = '0;
        for (int i = 0; i < NCH; i++) begin
            if (we && ch == i) begin
                if (cmd == 0) begin
                    mMode[i] = 0;
                    mRem[i]  = 0;
                end else if ((cmd == 1 || cmd == 2) && per != 0) begin
                    mMode[i] = cmd;
                    mRem[i]  = per;
                    mPer[i]  = per;
                end else if (cmd == 3 && mMode[i] != 0) begin
                    mRem[i] = mPer[i];
                end
            end else if (mBase && mMode[i] != 0) begin
                if (mRem[i] == 1) begin
                    mExpire[i] = 1'b1;
                    if (mMode[i] == 1) begin
                        mMode[i] = 0;
                        mRem[i]  = 0;
                    end else begin
                        mRem[i] = mPer[i];
                    end
                end else begin
                    mRem[i] = mRem[i] - 1;
                end
            end
        end
        if (ack && irqNow) mPend[sel] = 1'b0;
        mPend  = mPend | mExpire;
        mEdges = mEdges + 1;
        mBase  = ((mEdges % TC) == 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) activeMask[i] = (mMode[i] != 0);
        checkOutput("base_tick", 32'(base_tick), int'(mBase));
        checkOutput("ch_active", 32'(ch_active), int'(activeMask));
        checkOutput("ch_expire", 32'(ch_expire), int'(mExpire));
        checkOutput("irq",       32'(irq),       int'(mPend != 0));
        checkOutput("irq_ch",    32'(irq_ch),    lowestPending());
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    // Stops just before the edge on which the visible base tick is consumed.
    task automatic waitForTick();
        for (int k = 0; k < 2 * TC && !mBase; k++) idleCycles(1);
        if (!mBase) checkOutput("tick_wait", 32'(0), 1);
    endtask

    // Asserts reset between edges, checks outputs clear without a clock, then releases on a falling edge.
    task automatic doReset();
        cfg_we  = 1'b0;
        irq_ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_base_tick", 32'(base_tick), 0);
        checkOutput("rst_ch_active", 32'(ch_active), 0);
        checkOutput("rst_ch_expire", 32'(ch_expire), 0);
        checkOutput("rst_irq",       32'(irq),       0);
        checkOutput("rst_irq_ch",    32'(irq_ch),    0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        modelReset();
        doReset();
        idleCycles(30);

        applyStimulus(1'b1, 0, 1, 3, 1'b0);
        idleCycles(32);

        applyStimulus(1'b1, 1, 2, 2, 1'b0);
        idleCycles(61);
        applyStimulus(1'b1, 1, 0, 0, 1'b0);
        idleCycles(25);

        applyStimulus(1'b1, 2, 1, 1, 1'b0);
        idleCycles(12);
        repeat (3) applyStimulus(1'b0, 0, 0, 0, 1'b1);
        idleCycles(2);

        applyStimulus(1'b1, 0, 2, 1, 1'b0);
        waitForTick();
        idleCycles(1);
        waitForTick();
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("ack_vs_expire_irq", 32'(irq), 1);
        applyStimulus(1'b1, 0, 0, 0, 1'b0);
        repeat (4) applyStimulus(1'b0, 0, 0, 0, 1'b1);

        applyStimulus(1'b1, 3, 1, 0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 3, 1, 3, 1'b0);
        waitForTick();
        applyStimulus(1'b1, 3, 1, 2, 1'b0);
        applyStimulus(1'b1, 2, 3, 0, 1'b0);
        idleCycles(5);
        applyStimulus(1'b1, 3, 3, 0, 1'b0);
        idleCycles(40);

        applyStimulus(1'b1, 0, 1, 2, 1'b0);
        waitForTick();
        idleCycles(3);
        checkOutput("midreset_remaining_one", 32'(mRem[0]), 1);
        doReset();
        idleCycles(25);

        for (int n = 0; n < 2000; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                          $urandom_range(0, 2) == 0);
        end

`ifdef TICK_SCHED_PAUSE_EN
        begin
            int cycles;
            bit seen;
            doReset();
            seen = 1'b0;
            for (int k = 0; k < 3 * TC && !seen; k++) begin
                @(posedge clk);
                #1;
                seen = base_tick;
            end
            checkOutput("pause_first_tick", 32'(seen), 1);
            cycles = 0;
            seen   = 1'b0;
            while (!seen && cycles < 100) begin
                @(posedge clk);
                #1;
                cycles++;
                seen = base_tick;
                if (cycles == 3)  pauseIn = 1'b1;
                if (cycles == 28) pauseIn = 1'b0;
            end
            checkOutput("pause_period", 32'(cycles), TC + 25);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
